// File: rtl/crc_stream_pkg.sv
// Shared widths, state encoding and defaults for the CRC frame appender.
package crc_stream_pkg;

    localparam int CRC_W              = 8;
    localparam int COUNT_W            = 16;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [1:0] {
        PASS,
        WAIT_CRC,
        EMIT_CRC,
        DRAIN
    } state_e;

endpackage

// File: rtl/crc_stream_outreg.sv
// Single-entry registered output stage: data, last and a valid/ready handshake.
module crc_stream_outreg
    import crc_stream_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CRC_W-1:0] data_i,
    input  logic             last_i,
    input  logic             ready_i,
    output logic [CRC_W-1:0] data_o,
    output logic             valid_o,
    output logic             last_o,
    output logic             free_o
);

    logic [CRC_W-1:0] data_q;
    logic             valid_q;
    logic             last_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            last_q  <= last_i;
            valid_q <= 1'b1;
        end else if (ready_i) begin
            // NOTE: only valid drops on a handshake; data/last keep their value,
            // so nothing moves while the consumer is stalling.
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/crc_frame_appender.sv
// Forwards payload bytes and appends one CRC-8 byte per frame, counting completed frames.
// Define CRC_APPEND_TIMEOUT_EN to substitute 0x00 when the CRC fails to arrive in time.
module crc_frame_appender
    import crc_stream_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CRC_W-1:0]   s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    input  logic [CRC_W-1:0]   crc_in,
    input  logic               crc_valid,
    output logic [CRC_W-1:0]   m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic [COUNT_W-1:0] frame_count,
    output logic               timeout_err
);

    state_e             state_q;
    logic [CRC_W-1:0]   hold_q;
    logic [COUNT_W-1:0] frame_count_q;

    logic               out_free;
    logic               out_load;
    logic [CRC_W-1:0]   out_data;
    logic               out_last;
    logic               s_accept;
    logic               m_accept;

`ifdef CRC_APPEND_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q;
    logic             timeout_err_q;
`endif

    // s_ready is combinational, so it is masked explicitly while reset is asserted.
    assign s_ready  = reset && (state_q == PASS) && out_free;
    assign s_accept = s_valid && s_ready;
    assign m_accept = m_valid && m_ready;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        out_load = s_accept;
        out_data = s_data;
        out_last = 1'b0;
        if (state_q == EMIT_CRC) begin
            out_load = out_free;
            out_data = hold_q;
            out_last = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= PASS;
            hold_q        <= '0;
            frame_count_q <= '0;
`ifdef CRC_APPEND_TIMEOUT_EN
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
`ifdef CRC_APPEND_TIMEOUT_EN
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                PASS: begin
                    // A CRC arriving with the last beat skips the wait state entirely.
                    if (s_accept && s_last) begin
                        if (crc_valid) begin
                            hold_q  <= crc_in;
                            state_q <= EMIT_CRC;
                        end else begin
                            state_q <= WAIT_CRC;
                        end
                    end
                end
                WAIT_CRC: begin
                    if (crc_valid) begin
                        hold_q  <= crc_in;
                        state_q <= EMIT_CRC;
                    end
`ifdef CRC_APPEND_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        hold_q        <= '0;
                        timeout_err_q <= 1'b1;
                        state_q       <= EMIT_CRC;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                EMIT_CRC: begin
                    if (out_free) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (m_accept) begin
                        frame_count_q <= frame_count_q + 1'b1;
                        state_q       <= PASS;
                    end
                end
                default: state_q <= PASS;
            endcase
        end
    end

    crc_stream_outreg u_outreg (
        .clock   (clock),
        .reset   (reset),
        .load_i  (out_load),
        .data_i  (out_data),
        .last_i  (out_last),
        .ready_i (m_ready),
        .data_o  (m_data),
        .valid_o (m_valid),
        .last_o  (m_last),
        .free_o  (out_free)
    );

    assign frame_count = frame_count_q;

`ifdef CRC_APPEND_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_crc_frame_appender.sv
// Self-checking bench for crc_frame_appender; expected streams come from a queue model.
// Covers the timeout path when CRC_APPEND_TIMEOUT_EN is defined, the indefinite wait otherwise.
module tb_crc_frame_appender;

    localparam int TMO = 4;

    typedef logic [7:0] bq_t[$];

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  crc_in = 8'h00;
    logic        crc_valid = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic [15:0] frame_count;
    logic        timeout_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    bit          rand_ready = 1'b0;

    logic [8:0]  obs_q[$];
    int unsigned obs_cyc_q[$];
    logic [8:0]  exp_q[$];
    logic [15:0] exp_count = 16'h0000;

    crc_frame_appender #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .crc_in      (crc_in),
        .crc_valid   (crc_valid),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .frame_count (frame_count),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Beats that will complete at the coming rising edge.
    always @(negedge clock) begin
        if (reset && m_valid && m_ready) begin
            obs_q.push_back({m_last, m_data});
            obs_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    // crc_delay: 0 = CRC alongside last beat, >0 = cycles after last acceptance, <0 = none.
    task automatic send_frame(input bq_t p, input int crc_delay, input logic [7:0] crc);
        bit accepted;
        int guard;
        for (int i = 0; i < p.size(); i++) begin
            s_data  = p[i];
            s_valid = 1'b1;
            s_last  = (i == p.size() - 1);
            if (s_last && crc_delay == 0) begin
                crc_in    = crc;
                crc_valid = 1'b1;
            end
            accepted = 1'b0;
            guard    = 0;
            while (!accepted && guard < 500) begin
                @(negedge clock);
                accepted = s_ready;
                if (accepted && i == 0) acc_cyc = cyc;
                step();
                guard++;
            end
            if (!accepted) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_beat: s_ready stayed 0 for byte %0d, required 1 within 500 cycles", i);
                break;
            end
            exp_q.push_back({1'b0, p[i]});
        end
        s_valid   = 1'b0;
        s_last    = 1'b0;
        crc_valid = 1'b0;
        if (crc_delay > 0) begin
            repeat (crc_delay - 1) step();
            crc_in    = crc;
            crc_valid = 1'b1;
            step();
            crc_valid = 1'b0;
        end
        if (crc_delay >= 0) begin
            exp_q.push_back({1'b1, crc});
            exp_count++;
        end
    endtask

    task automatic wait_obs(input int n, input string name);
        int guard = 0;
        while (obs_q.size() < n && guard < 2000) begin
            step();
            guard++;
        end
        if (obs_q.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_wait: got %0d output beats, required %0d", name, obs_q.size(), n);
        end
    endtask

    task automatic drain_and_check(input string name);
        int         guard = 0;
        logic [8:0] e;
        logic [8:0] o;
        while (obs_q.size() < exp_q.size() && guard < 5000) begin
            step();
            guard++;
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL %s_len: got %0d beats, required %0d", name, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 'x;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s_beat: got last=%b data=%h, required last=%b data=%h",
                         name, o[8], o[7:0], e[8], e[7:0]);
            end
        end
        obs_q.delete();
        obs_cyc_q.delete();
        @(negedge clock);
        n_cmp++;
        if (frame_count !== exp_count) begin
            n_bad++;
            $display("FAIL %s_count: got frame_count=%h, required %h", name, frame_count, exp_count);
        end
        step();
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        m_ready = 1'b1;
        repeat (3) step();
        @(negedge clock);
        n_cmp += 6;
        if (m_valid !== 1'b0)      begin n_bad++; $display("FAIL rst_m_valid: got %b, required 0", m_valid); end
        if (m_last !== 1'b0)       begin n_bad++; $display("FAIL rst_m_last: got %b, required 0", m_last); end
        if (m_data !== 8'h00)      begin n_bad++; $display("FAIL rst_m_data: got %h, required 00", m_data); end
        if (s_ready !== 1'b0)      begin n_bad++; $display("FAIL rst_s_ready: got %b, required 0", s_ready); end
        if (frame_count !== 16'h0) begin n_bad++; $display("FAIL rst_count: got %h, required 0000", frame_count); end
        if (timeout_err !== 1'b0)  begin n_bad++; $display("FAIL rst_tmo: got %b, required 0", timeout_err); end
        step();
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_s_ready: got %b, required 1", s_ready); end
        step();
        exp_count = 16'h0000;
    endtask

    task automatic test_directed();
        bq_t p;
        p = {8'h68, 8'h01, 8'h02};
        m_ready = 1'b1;
        send_frame(p, 2, 8'hA5);
        wait_obs(4, "directed");
        n_cmp++;
        if (obs_cyc_q.size() == 0 || obs_cyc_q[0] !== acc_cyc + 1) begin
            n_bad++;
            $display("FAIL directed_latency: first output beat not in cycle %0d (accepted in %0d)", acc_cyc + 1, acc_cyc);
        end
        drain_and_check("directed");
    endtask

    task automatic test_crc_same_cycle();
        bq_t p;
        p = {8'($urandom), 8'($urandom)};
        m_ready = 1'b1;
        send_frame(p, 0, 8'h3C);
        wait_obs(3, "same_cycle");
        n_cmp++;
        if (obs_cyc_q.size() < 3 || obs_cyc_q[2] !== obs_cyc_q[1] + 1) begin
            n_bad++;
            $display("FAIL same_cycle_gap: CRC beat did not follow last payload beat in the next cycle");
        end
        drain_and_check("same_cycle");
    endtask

    task automatic test_backpressure();
        bq_t p;
        int  guard = 0;
        p = {8'h11, 8'h22};
        m_ready = 1'b1;
        send_frame(p, -1, 8'h00);
        crc_in    = 8'hA5;
        crc_valid = 1'b1;
        step();
        crc_valid = 1'b0;
        m_ready   = 1'b0;
        exp_q.push_back({1'b1, 8'hA5});
        exp_count++;
        @(negedge clock);
        while (!m_valid && guard < 50) begin
            step();
            @(negedge clock);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            n_cmp += 4;
            if (m_data !== 8'hA5)  begin n_bad++; $display("FAIL bp_data[%0d]: got %h, required a5", i, m_data); end
            if (m_last !== 1'b1)   begin n_bad++; $display("FAIL bp_last[%0d]: got %b, required 1", i, m_last); end
            if (s_ready !== 1'b0)  begin n_bad++; $display("FAIL bp_s_ready[%0d]: got %b, required 0", i, s_ready); end
            if (frame_count !== exp_count - 16'd1) begin
                n_bad++;
                $display("FAIL bp_count[%0d]: got %h, required %h", i, frame_count, exp_count - 16'd1);
            end
            step();
        end
        m_ready = 1'b1;
        drain_and_check("backpressure");
    endtask

    task automatic test_back_to_back();
        bq_t p;
        m_ready = 1'b1;
        p = {8'hC1};
        send_frame(p, 0, 8'h1C);
        p = {8'hD2};
        send_frame(p, 0, 8'h2D);
        wait_obs(4, "b2b");
        n_cmp++;
        if (obs_cyc_q.size() < 4 || obs_cyc_q[2] !== obs_cyc_q[1] + 2) begin
            n_bad++;
            $display("FAIL b2b_gap: next frame byte not accepted in the cycle after the CRC handshake");
        end
        drain_and_check("b2b");
    endtask

    task automatic test_random();
        bq_t p;
        rand_ready = 1'b1;
        for (int f = 0; f < 25; f++) begin
            p.delete();
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) p.push_back(8'($urandom));
            send_frame(p, int'($urandom_range(0, 4)), 8'($urandom));
        end
        drain_and_check("random");
        rand_ready = 1'b0;
        m_ready    = 1'b1;
    endtask

    task automatic test_crc_wait();
        bq_t p;
        int  pulses = 0;
        int  bad    = 0;
        m_ready = 1'b1;
        p = {8'h7E, 8'h81};
`ifdef CRC_APPEND_TIMEOUT_EN
        send_frame(p, -1, 8'h00);
        exp_q.push_back({1'b1, 8'h00});
        exp_count++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (timeout_err === 1'b1) pulses++;
            step();
        end
        n_cmp++;
        if (pulses != 1) begin n_bad++; $display("FAIL tmo_pulse: got %0d pulses, required 1", pulses); end
        drain_and_check("timeout");
        send_frame(p, TMO, 8'h5A);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (timeout_err === 1'b1) pulses++;
            step();
        end
        n_cmp++;
        if (pulses != 0) begin n_bad++; $display("FAIL tmo_crc_wins: got %0d pulses, required 0", pulses); end
        drain_and_check("tmo_crc_wins");
`else
        send_frame(p, -1, 8'h00);
        repeat (2) step();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (m_valid !== 1'b0 || s_ready !== 1'b0 || timeout_err !== 1'b0) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL wait_idle: got %0d active cycles, required 0", bad); end
        crc_in    = 8'hC3;
        crc_valid = 1'b1;
        step();
        crc_valid = 1'b0;
        exp_q.push_back({1'b1, 8'hC3});
        exp_count++;
        drain_and_check("late_crc");
`endif
    endtask

    task automatic test_reset_mid_frame();
        bq_t p;
        int  taken = 0;
        int  guard = 0;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_last  = 1'b0;
        while (taken < 2 && guard < 100) begin
            s_data = 8'($urandom);
            @(negedge clock);
            if (s_ready) taken++;
            step();
            guard++;
        end
        s_valid = 1'b0;
        reset   = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clock);
        n_cmp += 3;
        if (m_valid !== 1'b0)      begin n_bad++; $display("FAIL midrst_m_valid: got %b, required 0", m_valid); end
        if (m_last !== 1'b0)       begin n_bad++; $display("FAIL midrst_m_last: got %b, required 0", m_last); end
        if (frame_count !== 16'h0) begin n_bad++; $display("FAIL midrst_count: got %h, required 0000", frame_count); end
        obs_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
        exp_count = 16'h0000;
        step();
        p = {8'($urandom), 8'($urandom), 8'($urandom)};
        send_frame(p, 1, 8'($urandom));
        drain_and_check("after_reset");
    endtask

    task automatic test_wrap();
        bq_t p;
        m_ready = 1'b1;
        // Preload near the top of the range so the wrap is reached in a few frames.
        force dut.frame_count_q = 16'hFFFC;
        step();
        release dut.frame_count_q;
        exp_count = 16'hFFFC;
        for (int f = 0; f < 6; f++) begin
            p = {8'($urandom)};
            send_frame(p, 0, 8'($urandom));
            drain_and_check("wrap");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_crc_same_cycle();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_crc_wait();
        test_reset_mid_frame();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
